user_obi_burst_streamer: RTL
============================

// Module: user_obi_burst_streamer
// PURPOSE
//  Parametrised OBI streaming DMA engine for the user domain. Given base address, word count and stride,
//  it issues a burst of OBI word reads or writes with up to MaxOutstanding transactions in flight.
//  Read data leaves through a valid/ready stream to the compute module; write data enters through one.
//  Sits between the user-domain compute pipeline and the OBI crossbar (SRAM banks).
// PARAMETERS
//  ObiCfg          obi_pkg::ObiDefaultConfig  OBI widths (AddrWidth, DataWidth=32, IdWidth)
//  obi_req_t       logic                      OBI request struct type
//  obi_rsp_t       logic                      OBI response struct type
//  MaxOutstanding  2                          max granted-but-unanswered transactions (>=1)
//  FifoDepth       4                          read-data FIFO depth (>= MaxOutstanding)
//  LenWidth        16                         width of word-count field
// PORTS
//  clk_i        in   1          clock
//  rst_i        in   1          synchronous active-high reset
//  start_i      in   1          start burst; sampled only in IDLE
//  is_write_i   in   1          0 = read burst, 1 = write burst (latched at start)
//  base_addr_i  in   AddrWidth  first word address (latched at start)
//  len_i        in   LenWidth   number of words (latched at start)
//  stride_i     in   AddrWidth  byte increment between words (latched at start)
//  busy_o       out  1          burst in progress (state != IDLE)
//  done_o       out  1          one-cycle pulse: last response received
//  err_o        out  1          sticky: any r.err seen in current/last burst; cleared at next start
//  wdata_i      in   DataWidth  write stream data
//  wvalid_i     in   1          write stream valid
//  wready_o     out  1          write stream ready
//  rdata_o      out  DataWidth  read stream data (4 pixels)
//  rvalid_o     out  1          read stream valid
//  rready_i     in   1          read stream ready
//  obi_req_o    out  obi_req_t  OBI request (be='1, aid='0)
//  obi_rsp_i    in   obi_rsp_t  OBI response
// BEHAVIOUR
//  Reset: state IDLE, all counters 0, FIFO empty; busy_o, done_o, err_o, wready_o, rvalid_o, obi req = 0.
//  FSM: IDLE -start_i&len!=0-> ISSUE; IDLE -start_i&len==0-> IDLE with done_o pulse next cycle, no OBI traffic.
//   ISSUE -(last request granted)-> DRAIN; DRAIN -(outstanding==0)-> IDLE, done_o=1 in that transition cycle.
//  Request stage: registered A-channel; once req=1 it holds addr/we/wdata stable until gnt (OBI rule).
//  New request loaded when stage empty or granted this cycle, issued<len, outstanding(+incoming) < MaxOutstanding,
//   read: fifo_count + outstanding < FifoDepth (credit; FIFO never overflows);
//   write: wvalid_i=1 -> wready_o=1 in that cycle, wdata_i captured. wready_o=0 for read bursts / outside ISSUE.
//  Address k = base + k*stride, modulo 2^AddrWidth (wrap silently). Max one request per cycle; back-to-back
//   grants allowed, i.e. throughput 1 word/cycle with zero-wait memory.
//  Outstanding counter: +1 on req&gnt, -1 on rvalid; both same cycle -> unchanged. rvalid with counter 0 ignored
//   (stale response after reset).
//  Read rvalid pushes r.rdata into FIFO same cycle; rvalid_o = FIFO non-empty; data stable while rvalid_o&!rready_i.
//   Responses assumed in order (single target). Write responses only decrement counter.
//  r.err: sets err_o, burst continues to completion. start_i while busy ignored.
//  DRAIN->IDLE requires only outstanding==0; FIFO may still hold data, drained independently of the next burst.
//  Reset mid-burst: all state cleared next edge, FIFO flushed, pending request dropped.
// STRUCTURE
//  Package user_obi_streamer_pkg: state_t {IDLE, ISSUE, DRAIN}, mode_e {MODE_READ, MODE_WRITE}.
//  Sub-module user_stream_fifo (DataWidth, Depth; push/pop, count, sync active-high reset) for read data.
//  Top holds FSM, request stage, address/issue/outstanding counters.
// TESTING
//  Read len=4 base=0x1000 stride=4, zero-wait mem, rready=1 -> addrs 1000/1004/1008/100C back-to-back, 4 rvalid_o, one done_o.
//  Read len=8 with rready_i=0 -> at most FifoDepth=4 responses buffered, req stalls, no overflow; release -> all 8 in order.
//  Write len=3 stride=8, wvalid gapped 1-of-2 cycles, gnt delayed 2 cycles -> addr/wdata stable until gnt, 3 writes, done_o.
//  Mem latency 5, MaxOutstanding=2 -> never >2 in flight; gnt&rvalid same cycle keeps count; err on word 2 -> err_o=1, done_o.
//  len=0 -> no req, done_o pulse; base=0xFFFFFFFC stride=4 len=2 -> second addr 0x0; rst_i mid-burst -> IDLE, outputs 0, stale rvalid ignored.

Source files
------------

// File: rtl/user_obi_streamer_pkg.sv
// rtl/user_obi_streamer_pkg.sv - shared types for the user-domain OBI burst streamer
package user_obi_streamer_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef enum logic {MODE_READ, MODE_WRITE} mode_e;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_a_chan_default_t;

  typedef struct packed {
    logic                req;
    obi_a_chan_default_t a;
  } obi_req_default_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_r_chan_default_t;

  typedef struct packed {
    logic                gnt;
    logic                rvalid;
    obi_r_chan_default_t r;
  } obi_rsp_default_t;

endpackage

// File: rtl/user_stream_fifo.sv
// rtl/user_stream_fifo.sv - read-data FIFO; push/pop may coincide, push when full is dropped
module user_stream_fifo #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4,
  localparam int unsigned PtrW     = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  output logic [CntW-1:0]      count_o
);

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    do_pop  = pop_i && (count_o != '0);
    do_push = push_i && ((32'(count_o) != Depth) || do_pop);
    valid_o = (count_o != '0);
    data_o  = mem[rd_ptr];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + CntW'(1);
        2'b01:   count_o <= count_o - CntW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/user_obi_burst_streamer.sv
// rtl/user_obi_burst_streamer.sv - OBI burst DMA: strided word reads/writes with bounded outstanding
module user_obi_burst_streamer
  import user_obi_streamer_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg         = ObiDefaultConfig,
  parameter type         obi_req_t      = obi_req_default_t,
  parameter type         obi_rsp_t      = obi_rsp_default_t,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned LenWidth       = 16,
  localparam int unsigned AddrWidth     = ObiCfg.AddrWidth,
  localparam int unsigned DataWidth     = ObiCfg.DataWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 is_write_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [LenWidth-1:0]  len_i,
  input  logic [AddrWidth-1:0] stride_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 wvalid_i,
  output logic                 wready_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output obi_req_t             obi_req_o,
  input  obi_rsp_t             obi_rsp_i
);

  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned FCntW = $clog2(FifoDepth + 1);

  state_t               state_q, state_d;
  mode_e                mode_q;
  logic [LenWidth-1:0]  len_q, issued_q;
  logic [AddrWidth-1:0] stride_q, next_addr_q, req_addr_q;
  logic                 req_q, req_we_q;
  logic [DataWidth-1:0] req_wdata_q;
  logic [OutW-1:0]      out_q;
  logic                 err_q, zero_done_q;

  logic                 inc, dec, slot_free, credit_ok, can_load, load, push, pop;
  logic [31:0]          out_next;
  logic [FCntW-1:0]     fifo_count;
  logic                 rsp_unused;

  assign rsp_unused = ^obi_rsp_i.r.rid;

  always_comb begin
    inc       = req_q && obi_rsp_i.gnt;
    // A response with nothing outstanding is a leftover from before a reset.
    dec       = obi_rsp_i.rvalid && (out_q != '0);
    out_next  = 32'(out_q) + 32'(inc) - 32'(dec);
    slot_free = !req_q || obi_rsp_i.gnt;
    // Every granted or pending read already owns a FIFO slot, so the FIFO can never overflow.
    credit_ok = (mode_q == MODE_WRITE) ||
                (32'(fifo_count) + 32'(out_q) + 32'(inc) < FifoDepth);
    can_load  = (state_q == ISSUE) && slot_free && (issued_q != len_q) &&
                (out_next < MaxOutstanding) && credit_ok;
    load      = can_load && ((mode_q == MODE_READ) || wvalid_i);
    wready_o  = can_load && (mode_q == MODE_WRITE);
    push      = dec && (mode_q == MODE_READ);
    pop       = rvalid_o && rready_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && (len_i != '0)) state_d = ISSUE;
      ISSUE:   if (inc && (issued_q == len_q)) state_d = DRAIN;
      DRAIN:   if (out_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o             = (state_q != IDLE);
    done_o             = ((state_q == DRAIN) && (out_q == '0)) || zero_done_q;
    err_o              = err_q;
    obi_req_o          = '0;
    obi_req_o.req      = req_q;
    obi_req_o.a.addr   = req_addr_q;
    obi_req_o.a.we     = req_we_q;
    obi_req_o.a.be     = '1;
    obi_req_o.a.wdata  = req_wdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mode_q      <= MODE_READ;
      len_q       <= '0;
      issued_q    <= '0;
      stride_q    <= '0;
      next_addr_q <= '0;
      req_q       <= 1'b0;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      out_q       <= '0;
      err_q       <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= (state_q == IDLE) && start_i && (len_i == '0);
      if ((state_q == IDLE) && start_i) begin
        mode_q      <= is_write_i ? MODE_WRITE : MODE_READ;
        len_q       <= len_i;
        stride_q    <= stride_i;
        next_addr_q <= base_addr_i;
        issued_q    <= '0;
        err_q       <= 1'b0;
      end else if (dec && obi_rsp_i.r.err) begin
        err_q <= 1'b1;
      end
      if (load) begin
        req_q       <= 1'b1;
        req_addr_q  <= next_addr_q;
        req_we_q    <= (mode_q == MODE_WRITE);
        req_wdata_q <= (mode_q == MODE_WRITE) ? wdata_i : '0;
        next_addr_q <= next_addr_q + stride_q;
        issued_q    <= issued_q + LenWidth'(1);
      end else if (inc) begin
        req_q <= 1'b0;
      end
      case ({inc, dec})
        2'b10:   out_q <= out_q + OutW'(1);
        2'b01:   out_q <= out_q - OutW'(1);
        default: ;
      endcase
    end
  end

  user_stream_fifo #(
    .DataWidth (DataWidth),
    .Depth     (FifoDepth)
  ) u_rd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (obi_rsp_i.r.rdata),
    .pop_i   (pop),
    .data_o  (rdata_o),
    .valid_o (rvalid_o),
    .count_o (fifo_count)
  );

endmodule
